// File: rtl/rr_session_scheduler_if.sv
// rr_session_scheduler_if: request/done inputs and session status outputs of the scheduler.
interface rr_session_scheduler_if #(parameter int N = 4);
    localparam int OW = $clog2(N);
    logic [N-1:0]  req;
    logic [N-1:0]  done;
    logic [N-1:0]  grant;
    logic          busy;
    logic [OW-1:0] owner;
    logic          timeout_pulse;
    modport master(output req, done, input grant, busy, owner, timeout_pulse);
    modport slave(input req, done, output grant, busy, owner, timeout_pulse);
endinterface

// File: rtl/rr_session_scheduler.sv
// rr_session_scheduler: round-robin grant held for a whole session, ended by done,
// dropped request or timeout, followed by a one-cycle release gap.
module rr_session_scheduler #(
    parameter int N           = 4,
    parameter int MAX_SESSION = 16
) (
    input logic                  clk,
    input logic                  rst,
    rr_session_scheduler_if.slave bus
);
    localparam int OW = $clog2(N);
    localparam int CW = $clog2(MAX_SESSION);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_SESSION - 1);
    localparam logic [N-1:0]  ONE      = {{(N-1){1'b0}}, 1'b1};
    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
    state_t         state;
    logic [OW-1:0]  ptr;
    logic [OW-1:0]  pick;
    logic [CW-1:0]  cnt;
    logic [2*N-1:0] rot;
    logic           fin;
    logic           drop;
    logic           tmo;
    // rot[j] is the request j places after ptr; the lowest set j wins
    always_comb begin
        rot  = {bus.req, bus.req} >> ptr;
        pick = '0;
        for (int j = N - 1; j >= 0; j--)
            if (rot[j]) pick = OW'(int'(ptr) + j >= N ? int'(ptr) + j - N : int'(ptr) + j);
    end
    assign fin  = |(bus.done & bus.grant);
    assign drop = ~|(bus.req & bus.grant);
    assign tmo  = cnt == CNT_LAST;
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            bus.grant         <= '0;
            bus.busy          <= 1'b0;
            bus.owner         <= '0;
            bus.timeout_pulse <= 1'b0;
            ptr               <= '0;
            cnt               <= '0;
        end else begin
            bus.timeout_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        bus.grant <= ONE << pick;
                        bus.busy  <= 1'b1;
                        bus.owner <= pick;
                        cnt       <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (fin || drop || tmo) begin
                        bus.grant         <= '0;
                        bus.busy          <= 1'b0;
                        ptr               <= bus.owner == OW'(N - 1) ? '0 : bus.owner + 1'b1;
                        bus.timeout_pulse <= tmo && !fin && !drop;
                        state             <= RELEASE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rr_session_scheduler.sv
// tb_rr_session_scheduler: directed vector table plus hand-written session corner cases.
module tb_rr_session_scheduler;
    localparam int N  = 4;
    localparam int MS = 16;
    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] done;
        logic [3:0] grant;
        logic [1:0] owner;
        logic       tp;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    vec_t tbl[$];
    always #5 clk = ~clk;
    rr_session_scheduler_if #(.N(N)) bus();
    rr_session_scheduler #(.N(N), .MAX_SESSION(MS)) dut (.clk(clk), .rst(rst), .bus(bus));
    function automatic vec_t v(logic r, logic [3:0] q, logic [3:0] d, logic [3:0] g, logic [1:0] o, logic t);
        vec_t x;
        x.rst = r; x.req = q; x.done = d; x.grant = g; x.owner = o; x.tp = t;
        return x;
    endfunction
    task automatic apply(logic r, logic [3:0] q, logic [3:0] d);
        rst = r;
        bus.req = q;
        bus.done = d;
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(string name, logic [3:0] g, logic [1:0] o, logic t);
        logic [7:0] act;
        logic [7:0] exp;
        act = {bus.grant, bus.busy, bus.owner, bus.timeout_pulse};
        exp = {g, |g, o, t};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got grant=%b busy=%b owner=%0d tp=%b, expected grant=%b busy=%b owner=%0d tp=%b",
                     name, act[7:4], act[3], act[2:1], act[0], exp[7:4], exp[3], exp[2:1], exp[0]);
        end
    endtask
    task automatic do_reset();
        apply(1'b1, 4'b0000, 4'b0000);
        step();
        chk("reset", 4'b0000, 2'd0, 1'b0);
    endtask
    initial begin
        apply(1'b1, 4'b0000, 4'b0000);
        // reset with all requesting, then fairness with done in the first grant cycle
        tbl.push_back(v(1, 4'hF, 4'h0, 4'h0, 0, 0));
        tbl.push_back(v(1, 4'hF, 4'h0, 4'h0, 0, 0));
        tbl.push_back(v(0, 4'hF, 4'h0, 4'h1, 0, 0));
        tbl.push_back(v(0, 4'hF, 4'h1, 4'h0, 0, 0));
        tbl.push_back(v(0, 4'hF, 4'h0, 4'h0, 0, 0));
        tbl.push_back(v(0, 4'hF, 4'h0, 4'h2, 1, 0));
        tbl.push_back(v(0, 4'hF, 4'h2, 4'h0, 1, 0));
        tbl.push_back(v(0, 4'hF, 4'h0, 4'h0, 1, 0));
        tbl.push_back(v(0, 4'hF, 4'h0, 4'h4, 2, 0));
        tbl.push_back(v(0, 4'hF, 4'h4, 4'h0, 2, 0));
        tbl.push_back(v(0, 4'hF, 4'h0, 4'h0, 2, 0));
        tbl.push_back(v(0, 4'hF, 4'h0, 4'h8, 3, 0));
        tbl.push_back(v(0, 4'hF, 4'h8, 4'h0, 3, 0));
        tbl.push_back(v(0, 4'hF, 4'h0, 4'h0, 3, 0));
        tbl.push_back(v(0, 4'hF, 4'h0, 4'h1, 0, 0));
        tbl.push_back(v(0, 4'hF, 4'h1, 4'h0, 0, 0));
        // single requester 2, done in its 3rd grant cycle, then re-granted
        tbl.push_back(v(1, 4'h4, 4'h0, 4'h0, 0, 0));
        tbl.push_back(v(0, 4'h4, 4'h0, 4'h4, 2, 0));
        tbl.push_back(v(0, 4'h4, 4'h0, 4'h4, 2, 0));
        tbl.push_back(v(0, 4'h4, 4'h0, 4'h4, 2, 0));
        tbl.push_back(v(0, 4'h4, 4'h4, 4'h0, 2, 0));
        tbl.push_back(v(0, 4'h4, 4'h0, 4'h0, 2, 0));
        tbl.push_back(v(0, 4'h4, 4'h0, 4'h4, 2, 0));
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].rst, tbl[i].req, tbl[i].done);
            step();
            chk($sformatf("row%0d", i), tbl[i].grant, tbl[i].owner, tbl[i].tp);
        end
        // timeout: 16 grant cycles, pulse in release, then pointer moves past owner 1
        do_reset();
        apply(1'b0, 4'b0010, 4'b0000);
        for (int c = 1; c <= MS; c++) begin
            step();
            chk($sformatf("tmo_cyc%0d", c), 4'b0010, 2'd1, 1'b0);
        end
        step();
        chk("tmo_release", 4'b0000, 2'd1, 1'b1);
        apply(1'b0, 4'b1111, 4'b0000);
        step();
        chk("tmo_idle", 4'b0000, 2'd1, 1'b0);
        step();
        chk("tmo_next", 4'b0100, 2'd2, 1'b0);
        // done coincident with timeout, non-owner done ignored mid-session
        do_reset();
        apply(1'b0, 4'b0010, 4'b0000);
        step();
        chk("co_cyc1", 4'b0010, 2'd1, 1'b0);
        for (int c = 2; c <= MS; c++) begin
            bus.done = (c == 5 || c == 6) ? 4'b1000 : 4'b0000;
            step();
            chk($sformatf("co_cyc%0d", c), 4'b0010, 2'd1, 1'b0);
        end
        bus.done = 4'b0010;
        step();
        chk("co_release", 4'b0000, 2'd1, 1'b0);
        bus.done = 4'b0000;
        step();
        chk("co_idle", 4'b0000, 2'd1, 1'b0);
        step();
        chk("co_regrant", 4'b0010, 2'd1, 1'b0);
        // request dropped in grant cycle 5
        do_reset();
        apply(1'b0, 4'b0010, 4'b0000);
        for (int c = 1; c <= 5; c++) begin
            step();
            chk($sformatf("drop_cyc%0d", c), 4'b0010, 2'd1, 1'b0);
        end
        bus.req = 4'b0000;
        step();
        chk("drop_release", 4'b0000, 2'd1, 1'b0);
        step();
        chk("drop_idle", 4'b0000, 2'd1, 1'b0);
        step();
        chk("drop_stay_idle", 4'b0000, 2'd1, 1'b0);
        // reset in grant cycle 4 of requester 2
        do_reset();
        apply(1'b0, 4'b0100, 4'b0000);
        for (int c = 1; c <= 4; c++) begin
            step();
            chk($sformatf("mid_cyc%0d", c), 4'b0100, 2'd2, 1'b0);
        end
        rst = 1'b1;
        step();
        chk("mid_reset", 4'b0000, 2'd0, 1'b0);
        rst = 1'b0;
        step();
        chk("mid_regrant", 4'b0100, 2'd2, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
